// File: rtl/router_sync_param_if.sv
// Bundle of signals between the router FSM/register block, the synchronizer and the output FIFO bank.
interface router_sync_param_if #(
    parameter int NUM_CH = 3,
    parameter int ADDR_W = 2
);
    logic              detect_add;
    logic [ADDR_W-1:0] data_in;
    logic              write_en_reg;
    logic [NUM_CH-1:0] read_en;
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] to_clr;
    logic [NUM_CH-1:0] write_en;
    logic              fifo_full;
    logic [NUM_CH-1:0] valid_out;
    logic [NUM_CH-1:0] soft_rst;
    logic              addr_err;
    logic [NUM_CH-1:0] to_status;

    modport master (
        output detect_add, data_in, write_en_reg, read_en, empty, full, to_clr,
        input  write_en, fifo_full, valid_out, soft_rst, addr_err, to_status
    );

    modport slave (
        input  detect_add, data_in, write_en_reg, read_en, empty, full, to_clr,
        output write_en, fifo_full, valid_out, soft_rst, addr_err, to_status
    );
endinterface

// File: rtl/router_sync_param.sv
// NUM_CH-channel router synchronizer: captures the destination address, steers FIFO writes,
// and issues a one-cycle soft reset to any channel whose data sits unread for TIMEOUT cycles.
module router_sync_param #(
    parameter int NUM_CH  = 3,
    parameter int ADDR_W  = 2,
    parameter int TIMEOUT = 30
) (
    input logic               clk,
    input logic               reset_in,
    router_sync_param_if.slave bus
);
    localparam int                TW         = $clog2(TIMEOUT);
    localparam logic [TW-1:0]     T_LAST     = TW'(TIMEOUT - 1);
    // One extra bit so NUM_CH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0]   NUM_CH_EXT = (ADDR_W + 1)'(NUM_CH);

    logic [ADDR_W-1:0] addr_reg;
    logic              addr_vld_reg;
    logic              addr_err_reg;
    logic              in_range;
    logic [NUM_CH-1:0] addr_sel;
    logic [NUM_CH-1:0] soft_rst_reg;
    logic [NUM_CH-1:0] to_status_reg;

    assign in_range = ({1'b0, bus.data_in} < NUM_CH_EXT);

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            addr_reg     <= '0;
            addr_vld_reg <= 1'b0;
            addr_err_reg <= 1'b0;
        end else if (bus.detect_add) begin
            addr_reg     <= bus.data_in;
            addr_vld_reg <= in_range;
            addr_err_reg <= !in_range;
        end else begin
            addr_err_reg <= 1'b0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [TW-1:0] timer_reg;
            logic [TW-1:0] timer_next;
            logic          soft_rst_next;
            logic          to_status_next;
            logic          stall;

            assign addr_sel[gi] = addr_vld_reg && (addr_reg == ADDR_W'(gi));
            assign stall        = !bus.empty[gi] && !bus.read_en[gi];

            always_comb begin
                timer_next     = '0;
                soft_rst_next  = 1'b0;
                to_status_next = to_status_reg[gi];
                if (stall) begin
                    if (timer_reg == T_LAST) begin
                        soft_rst_next = 1'b1;
                    end else begin
                        timer_next = timer_reg + 1'b1;
                    end
                end
                // A timeout on the same edge as a clear must stay visible.
                if (soft_rst_next) begin
                    to_status_next = 1'b1;
                end else if (bus.to_clr[gi]) begin
                    to_status_next = 1'b0;
                end
            end

            always_ff @(posedge clk or negedge reset_in) begin
                if (!reset_in) begin
                    timer_reg         <= '0;
                    soft_rst_reg[gi]  <= 1'b0;
                    to_status_reg[gi] <= 1'b0;
                end else begin
                    timer_reg         <= timer_next;
                    soft_rst_reg[gi]  <= soft_rst_next;
                    to_status_reg[gi] <= to_status_next;
                end
            end
        end
    endgenerate

    assign bus.write_en  = bus.write_en_reg ? addr_sel : '0;
    assign bus.fifo_full = |(bus.full & addr_sel);
    assign bus.valid_out = ~bus.empty;
    assign bus.soft_rst  = soft_rst_reg;
    assign bus.addr_err  = addr_err_reg;
    assign bus.to_status = to_status_reg;
endmodule

// File: tb/tb_router_sync_param.sv
// Scenario bench for router_sync_param (NUM_CH=3, ADDR_W=2, TIMEOUT=30) with an expected-value queue.
module tb_router_sync_param;
    localparam int NUM_CH  = 3;
    localparam int ADDR_W  = 2;
    localparam int TIMEOUT = 30;

    logic clk = 1'b0;
    logic reset_in;
    always #5 clk = ~clk;

    router_sync_param_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) bus ();

    router_sync_param #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .reset_in (reset_in),
        .bus      (bus)
    );

    typedef struct packed {
        logic [2:0] we;
        logic       ff;
        logic       ae;
        logic [2:0] sr;
        logic [2:0] ts;
        logic [2:0] vo;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic obs_t observe();
        obs_t o;
        o.we = bus.write_en;
        o.ff = bus.fifo_full;
        o.ae = bus.addr_err;
        o.sr = bus.soft_rst;
        o.ts = bus.to_status;
        o.vo = bus.valid_out;
        return o;
    endfunction

    task automatic push_exp(input logic [2:0] we, input logic ff, input logic ae,
                            input logic [2:0] sr, input logic [2:0] ts, input logic [2:0] vo);
        exp_q.push_back(obs_t'({we, ff, ae, sr, ts, vo}));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t got, want;
        reset_in         = 1'b0;
        bus.empty        = 3'b010;
        bus.full         = 3'b111;
        bus.write_en_reg = 1'b1;
        bus.detect_add   = 1'b1;
        bus.data_in      = 2'd1;
        push_exp(3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 3'b101);
        #12;
        got = observe(); want = exp_q.pop_front(); n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL reset: got we/ff/ae/sr/ts/vo=%b required %b", got, want);
        end else $display("reset: we/ff/ae/sr/ts/vo=%b ok", got);
        bus.empty        = 3'b111;
        bus.full         = 3'b000;
        bus.write_en_reg = 1'b0;
        bus.detect_add   = 1'b0;
        @(negedge clk);
        reset_in = 1'b1;
        tick();
    endtask

    task automatic test_addr_capture();
        obs_t got, want;
        logic [2:0] one_hot;
        for (int a = 0; a < NUM_CH; a++) begin
            one_hot          = 3'b001 << a;
            bus.detect_add   = 1'b1;
            bus.data_in      = 2'(a);
            bus.write_en_reg = 1'b1;
            bus.full         = one_hot;
            push_exp(one_hot, 1'b1, 1'b0, 3'b000, 3'b000, 3'b000);
            tick();
            got = observe(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL capture a=%0d: got %b required %b", a, got, want);
            end else $display("capture a=%0d: %b ok", a, got);

            bus.detect_add = 1'b0;
            bus.full       = ~one_hot;
            push_exp(one_hot, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000);
            #1;
            got = observe(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL full_other a=%0d: got %b required %b", a, got, want);
            end else $display("full_other a=%0d: %b ok", a, got);

            bus.write_en_reg = 1'b0;
            bus.full         = 3'b111;
            push_exp(3'b000, 1'b1, 1'b0, 3'b000, 3'b000, 3'b000);
            #1;
            got = observe(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL no_write a=%0d: got %b required %b", a, got, want);
            end else $display("no_write a=%0d: %b ok", a, got);
        end
        bus.full = 3'b000;
    endtask

    task automatic test_bad_addr();
        obs_t got, want;
        bus.detect_add   = 1'b1;
        bus.data_in      = 2'd3;
        bus.full         = 3'b111;
        bus.write_en_reg = 1'b1;
        push_exp(3'b000, 1'b0, 1'b1, 3'b000, 3'b000, 3'b000);
        tick();
        got = observe(); want = exp_q.pop_front(); n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL bad_addr: got %b required %b", got, want);
        end else $display("bad_addr: %b ok", got);
        bus.detect_add = 1'b0;
        push_exp(3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000);
        tick();
        got = observe(); want = exp_q.pop_front(); n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL bad_addr_pulse_end: got %b required %b", got, want);
        end else $display("bad_addr_pulse_end: %b ok", got);
        bus.write_en_reg = 1'b0;
        bus.full         = 3'b000;
    endtask

    task automatic test_timeout();
        obs_t got, want;
        bus.empty   = 3'b110;
        bus.read_en = 3'b000;
        for (int c = 1; c <= 31; c++) begin
            push_exp(3'b000, 1'b0, 1'b0, (c == 30) ? 3'b001 : 3'b000,
                     (c >= 30) ? 3'b001 : 3'b000, 3'b001);
            tick();
            got = observe(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL timeout c=%0d: got %b required %b", c, got, want);
            end else $display("timeout c=%0d: %b ok", c, got);
        end
        bus.to_clr = 3'b001;
        push_exp(3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 3'b001);
        tick();
        got = observe(); want = exp_q.pop_front(); n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL timeout_clear: got %b required %b", got, want);
        end else $display("timeout_clear: %b ok", got);
        bus.to_clr = 3'b000;
        bus.empty  = 3'b111;
        tick();
    endtask

    task automatic test_read_restart();
        obs_t got, want;
        bus.empty = 3'b110;
        for (int c = 1; c <= 51; c++) begin
            bus.read_en = (c == 20) ? 3'b001 : 3'b000;
            push_exp(3'b000, 1'b0, 1'b0, (c == 50) ? 3'b001 : 3'b000,
                     (c >= 50) ? 3'b001 : 3'b000, 3'b001);
            tick();
            got = observe(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL read_restart c=%0d: got %b required %b", c, got, want);
            end else $display("read_restart c=%0d: %b ok", c, got);
        end
        bus.read_en = 3'b000;
        bus.empty   = 3'b111;
        bus.to_clr  = 3'b111;
        push_exp(3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000);
        tick();
        got = observe(); want = exp_q.pop_front(); n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL read_restart_clear: got %b required %b", got, want);
        end else $display("read_restart_clear: %b ok", got);
        bus.to_clr = 3'b000;
    endtask

    task automatic test_simultaneous();
        obs_t got, want;
        bus.empty = 3'b010;
        for (int c = 1; c <= 31; c++) begin
            bus.to_clr = (c == 30) ? 3'b001 : 3'b000;
            push_exp(3'b000, 1'b0, 1'b0, (c == 30) ? 3'b101 : 3'b000,
                     (c >= 30) ? 3'b101 : 3'b000, 3'b101);
            tick();
            got = observe(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL simultaneous c=%0d: got %b required %b", c, got, want);
            end else $display("simultaneous c=%0d: %b ok", c, got);
        end
        bus.to_clr = 3'b001;
        push_exp(3'b000, 1'b0, 1'b0, 3'b000, 3'b100, 3'b101);
        tick();
        got = observe(); want = exp_q.pop_front(); n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL simultaneous_clear: got %b required %b", got, want);
        end else $display("simultaneous_clear: %b ok", got);
        bus.to_clr = 3'b000;
        bus.empty  = 3'b111;
        tick();
    endtask

    task automatic test_async_reset();
        obs_t got, want;
        bus.empty = 3'b110;
        for (int c = 1; c <= 30; c++) begin
            if (c == 16) bus.empty = 3'b100;
            if (c == 30) begin
                bus.detect_add = 1'b1;
                bus.data_in    = 2'd3;
            end
            push_exp(3'b000, 1'b0, (c == 30), (c == 30) ? 3'b001 : 3'b000,
                     (c == 30) ? 3'b101 : 3'b100, (c >= 16) ? 3'b011 : 3'b001);
            tick();
            got = observe(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL pre_reset c=%0d: got %b required %b", c, got, want);
            end else $display("pre_reset c=%0d: %b ok", c, got);
        end
        #2;
        reset_in = 1'b0;
        push_exp(3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 3'b011);
        #1;
        got = observe(); want = exp_q.pop_front(); n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL async_reset: got %b required %b", got, want);
        end else $display("async_reset: %b ok", got);
        bus.detect_add   = 1'b0;
        bus.write_en_reg = 1'b1;
        tick();
        tick();
        reset_in = 1'b1;
        for (int c = 1; c <= 31; c++) begin
            push_exp(3'b000, 1'b0, 1'b0, (c == 30) ? 3'b011 : 3'b000,
                     (c >= 30) ? 3'b011 : 3'b000, 3'b011);
            tick();
            got = observe(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL post_reset c=%0d: got %b required %b", c, got, want);
            end else $display("post_reset c=%0d: %b ok", c, got);
        end
        bus.write_en_reg = 1'b0;
        bus.empty        = 3'b111;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_in         = 1'b0;
        bus.detect_add   = 1'b0;
        bus.data_in      = '0;
        bus.write_en_reg = 1'b0;
        bus.read_en      = '0;
        bus.empty        = '1;
        bus.full         = '0;
        bus.to_clr       = '0;
        test_reset();
        test_addr_capture();
        test_bad_addr();
        test_timeout();
        test_read_restart();
        test_simultaneous();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
